ascensor_sched: RTL and testbench
=================================

Name: ascensor_sched

Overview:
- Floor-request scheduler for the elevator car.
- Latches floor calls and chooses travel direction with SCAN ordering: keep going while calls remain ahead, otherwise reverse.
- Sequences the 4-bit floor counter through its enb/modo/data controls. The counter's Q output is the car position.
- Sits between the call buttons and the floor counter. Also drives door and motion indicators.

Parameters:
- FLOORS, 8: number of floors, 2..16. Floors are numbered 0..FLOORS-1.
- TRAVEL, 4: cycles per floor step, >=2.
- DOOR, 6: cycles the door stays open per stop, >=1.
- HOME, 0: floor loaded into the counter after reset or on a position fault.

Ports:
- clk  input  1: system clock, rising edge.
- rst  input  1: asynchronous, active-low reset.
- req  input  FLOORS: floor calls. Any bit high at a clk edge sets the matching pend bit.
- q  input  4: floor counter output, the current floor.
- enb  output  1: counter enable.
- modo  output  1: counter mode. 1 = parallel load of data; 0 = count.
- data  output  4: counter load value.
- dir  output  1: count direction for the counter. 1 = up, 0 = down.
- door_open  output  1: door open indicator.
- moving  output  1: car traveling.
- pend  output  FLOORS: pending calls, visible to the bench.

Behaviour:
- All outputs are registers, updated on clk rising edges.
- While rst=0, the block is held in reset with these values:
  - state INIT, enb=0, modo=1, data=HOME, dir=1
  - door_open=0, moving=0, pend=0, timer=0.
- Counter contract:
  - enb=1 with modo=1: q becomes data at the edge.
  - enb=1 with modo=0: q steps by +1 if dir=1, -1 if dir=0.
  - enb=0: q holds.
- Call latch: pend_next = (pend | req) & ~clr.
  - clr is onehot(q) in every cycle spent in DOOR, and in the cycle entering DOOR.
  - Clear wins over set on the same bit.
- States:
  - INIT: enb=1, modo=1, data=HOME for exactly one cycle, then IDLE.
  - IDLE: moving=0, enb=0.
    - If pend[q] is set, go to DOOR.
    - Else, if pend is nonzero, pick a direction and go to MOVE. Pick up (dir=1) if any call lies above q, and either dir was already 1 or no call lies below q. Otherwise pick down (dir=0).
    - Else stay in IDLE.
  - MOVE: moving=1. timer counts TRAVEL cycles.
    - enb=1, modo=0 is asserted for exactly one cycle, the TRAVEL-th cycle in MOVE.
    - Then go to CHECK.
  - CHECK: one cycle; q now shows the new floor. enb=0, moving=1.
    - If pend[q] is set, go to DOOR.
    - Else, if any call lies beyond q in direction dir, go back to MOVE.
    - Else go to IDLE, which re-runs direction selection.
  - DOOR: door_open=1, moving=0 for exactly DOOR cycles, then IDLE.
    - Calls to q while in DOOR are absorbed and cleared. They do not restart the door timer.
    - Calls to other floors accumulate normally.
- Per-floor latency is TRAVEL+1 cycles. Going from IDLE to DOOR across n floors takes 1 + n*(TRAVEL+1) cycles.
- Position limits: the car never steps below 0 or above FLOORS-1, because it only moves toward a pending floor. enb is never asserted with modo=0 in IDLE, CHECK or DOOR.
- Fault: if q >= FLOORS in IDLE or CHECK, go to INIT (reload HOME). pend is kept.
- Simultaneous calls above and below with no prior direction: dir defaults to 1, so up wins.
- Reset mid-operation: immediate return to the reset values, pending calls are lost, and the INIT reload is repeated.

Test Plan:
- Reset then release, HOME=0:
  - one cycle of enb=1, modo=1, data=0
  - q=0, idle with moving=0, pend=0.
- Pulse req[3] for one cycle at q=0:
  - dir=1 and exactly 3 enb pulses spaced 5 cycles apart
  - q=3, and door_open rises 16 cycles after IDLE sees pend[3]
  - door_open held 6 cycles, pend[3] cleared.
- At q=3 idle, pulse req[5] and req[1] together:
  - car goes up first to 5 (door 6 cycles), then dir=0 down to 1
  - pend=0 at end.
- Hold req[3] while parked at q=3:
  - door opens next cycle, stays exactly 6 cycles, no enb pulses
  - pend[3] stays 0 throughout.
- While MOVE from 0 toward 6, pulse req[4] before reaching floor 4:
  - stops at 4 (door 6 cycles), then continues to 6.
  - Pulse req[2] after passing 2: it is served only after 6, on the down sweep.
- Assert rst=0 mid-MOVE at q=2:
  - outputs return to the reset values immediately, pend=0
  - after release, INIT reloads q=0 and no stale pending call is served.
- Force the counter model to q=12 with FLOORS=8:
  - block enters INIT and reloads HOME (q=0)
  - pend is preserved.

Source files
------------

// File: rtl/ascensor_sched.sv
// ============================================================================
//  ascensor_sched : SCAN floor-request scheduler driving an external floor
//                   counter (enb/modo/data/dir) plus door and motion flags.
//  Revision 1.0
// ============================================================================
`default_nettype none

module ascensor_sched #(
  parameter int FLOORS = 8,
  parameter int TRAVEL = 4,
  parameter int DOOR   = 6,
  parameter int HOME   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOORS-1:0] req,
  input  logic [3:0]        q,
  output logic              enb,
  output logic              modo,
  output logic [3:0]        data,
  output logic              dir,
  output logic              door_open,
  output logic              moving,
  output logic [FLOORS-1:0] pend
);

  localparam int TMAX = (TRAVEL > DOOR) ? TRAVEL : DOOR;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_MOVE  = 3'd2,
    S_CHECK = 3'd3,
    S_DOOR  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [FLOORS-1:0] pend_q, pend_d;
  logic              enb_q, modo_q, dir_q, door_q, moving_q;
  logic [3:0]        data_q;

  logic              above, below, here, fault, ahead, pick_up, clr;
  logic [FLOORS-1:0] hit_mask;

  // Floor comparisons are done at 5 bits so FLOORS=16 never aliases onto q.
  always_comb begin
    above    = 1'b0;
    below    = 1'b0;
    here     = 1'b0;
    hit_mask = '0;
    for (int i = 0; i < FLOORS; i++) begin
      if (5'(i) > {1'b0, q}) above = above | pend_q[i];
      if (5'(i) < {1'b0, q}) below = below | pend_q[i];
      if (5'(i) == {1'b0, q}) begin
        here        = here | pend_q[i];
        hit_mask[i] = 1'b1;
      end
    end
    fault   = ({1'b0, q} >= 5'(FLOORS));
    ahead   = dir_q ? above : below;
    pick_up = above & (dir_q | ~below);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (enb_q) state_d = S_IDLE;
      S_IDLE: begin
        if (fault)        state_d = S_INIT;
        else if (here)    state_d = S_DOOR;
        else if (|pend_q) state_d = S_MOVE;
      end
      S_MOVE:  if (timer_q == TW'(TRAVEL)) state_d = S_CHECK;
      S_CHECK: begin
        if (fault)      state_d = S_INIT;
        else if (here)  state_d = S_DOOR;
        else if (ahead) state_d = S_MOVE;
        else            state_d = S_IDLE;
      end
      S_DOOR:  if (timer_q == TW'(DOOR)) state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase

    timer_d = (state_d == state_q) ? timer_q + TW'(1) : TW'(1);
    clr     = (state_q == S_DOOR) || (state_d == S_DOOR);
    pend_d  = (pend_q | req) & ~(clr ? hit_mask : '0);
  end

  // Outputs are registered as a function of the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_INIT;
      timer_q  <= '0;
      pend_q   <= '0;
      enb_q    <= 1'b0;
      modo_q   <= 1'b1;
      data_q   <= 4'(HOME);
      dir_q    <= 1'b1;
      door_q   <= 1'b0;
      moving_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      data_q   <= 4'(HOME);
      enb_q    <= 1'b0;
      modo_q   <= 1'b1;
      door_q   <= 1'b0;
      moving_q <= 1'b0;
      timer_q  <= '0;
      case (state_d)
        S_INIT:  enb_q <= 1'b1;
        S_MOVE: begin
          moving_q <= 1'b1;
          modo_q   <= 1'b0;
          timer_q  <= timer_d;
          enb_q    <= (timer_d == TW'(TRAVEL));
          if (state_q == S_IDLE) dir_q <= pick_up;
        end
        S_CHECK: moving_q <= 1'b1;
        S_DOOR: begin
          door_q  <= 1'b1;
          timer_q <= timer_d;
        end
        default: ;
      endcase
    end
  end

  assign enb       = enb_q;
  assign modo      = modo_q;
  assign data      = data_q;
  assign dir       = dir_q;
  assign door_open = door_q;
  assign moving    = moving_q;
  assign pend      = pend_q;

endmodule

`default_nettype wire

// File: tb/tb_ascensor_sched.sv
// ============================================================================
//  tb_ascensor_sched : directed bench for ascensor_sched with a floor-counter
//                      model closing the q loop.
//  Revision 1.0
// ============================================================================
`default_nettype none

module tb_ascensor_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] req = 8'h00;
  logic [3:0] q_m = 4'd0;
  logic       force_en = 1'b0;
  logic [3:0] force_val = 4'd0;

  logic       enb, modo, dir, door_open, moving;
  logic [3:0] data;
  logic [7:0] pend;

  int checks = 0;
  int errors = 0;
  int steps = 0;
  int bad_steps = 0;

  always #5 clk = ~clk;

  ascensor_sched #(.FLOORS(8), .TRAVEL(4), .DOOR(6), .HOME(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .q         (q_m),
    .enb       (enb),
    .modo      (modo),
    .data      (data),
    .dir       (dir),
    .door_open (door_open),
    .moving    (moving),
    .pend      (pend)
  );

  // Floor counter model; force path injects out-of-range positions.
  always @(posedge clk) begin
    if (force_en) q_m <= force_val;
    else if (enb) q_m <= modo ? data : (dir ? q_m + 4'd1 : q_m - 4'd1);
    if (enb && !modo) begin
      steps <= steps + 1;
      if (!moving) bad_steps <= bad_steps + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_door(output int n);
    n = 0;
    while (!door_open && n < 200) begin
      tick(1);
      n++;
    end
  endtask

  task automatic wait_close(output int n);
    n = 0;
    while (door_open && n < 200) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   base;
    logic flag;

    // Reset with the counter parked at a stale floor
    force_en = 1'b1; force_val = 4'd7;
    tick(1);
    force_en = 1'b0;
    tick(1);
    check("rst_enb", enb, 0);
    check("rst_modo", modo, 1);
    check("rst_data", data, 0);
    check("rst_dir", dir, 1);
    check("rst_door", door_open, 0);
    check("rst_moving", moving, 0);
    check("rst_pend", pend, 0);
    check("rst_q_held", q_m, 7);
    rst = 1'b1;
    tick(1);
    check("init_enb", enb, 1);
    check("init_modo", modo, 1);
    check("init_data", data, 0);
    tick(1);
    check("home_q", q_m, 0);
    check("idle_enb", enb, 0);
    check("idle_moving", moving, 0);
    check("idle_pend", pend, 0);

    // Single call three floors up
    base = steps;
    req = 8'h08; tick(1); req = 8'h00;
    check("t2_pend", pend, 8'h08);
    wait_door(n);
    check("t2_latency", n, 16);
    check("t2_q", q_m, 3);
    check("t2_dir", dir, 1);
    check("t2_steps", steps - base, 3);
    check("t2_pend_clr", pend, 0);
    wait_close(n);
    check("t2_door_len", n, 6);

    // Held call at the current floor
    base = steps;
    req = 8'h08; tick(1);
    wait_door(n);
    check("t4_latency", n, 1);
    flag = 1'b0; n = 0;
    while (door_open && n < 100) begin
      if (pend[3]) flag = 1'b1;
      if (n == 3) req = 8'h00;
      tick(1);
      n++;
    end
    req = 8'h00;
    check("t4_door_len", n, 6);
    check("t4_absorbed", flag, 0);
    tick(3);
    check("t4_no_reopen", door_open, 0);
    check("t4_pend", pend, 0);
    check("t4_steps", steps - base, 0);

    // Calls above and below: up first, then down
    base = steps;
    req = 8'h22; tick(1); req = 8'h00;
    wait_door(n);
    check("t3_up_latency", n, 11);
    check("t3_up_q", q_m, 5);
    check("t3_up_pend", pend, 8'h02);
    wait_close(n);
    check("t3_up_door", n, 6);
    wait_door(n);
    check("t3_dn_latency", n, 21);
    check("t3_dn_q", q_m, 1);
    check("t3_dn_dir", dir, 0);
    check("t3_dn_pend", pend, 0);
    check("t3_steps", steps - base, 6);
    wait_close(n);

    // Return to floor 0
    req = 8'h01; tick(1); req = 8'h00;
    wait_door(n);
    check("t5_home_latency", n, 6);
    check("t5_home_q", q_m, 0);
    wait_close(n);

    // Trip 0->6 with intermediate stop at 4, call at 2 after passing it
    req = 8'h40; tick(1); req = 8'h00;
    tick(7);
    req = 8'h10; tick(1); req = 8'h00;
    check("t5_mid_q", q_m, 1);
    wait_door(n);
    check("t5_stop4_latency", n, 13);
    check("t5_stop4_q", q_m, 4);
    tick(1);
    req = 8'h04; tick(1); req = 8'h00;
    check("t5_pend_mid", pend, 8'h44);
    wait_close(n);
    check("t5_stop4_close", n, 4);
    wait_door(n);
    check("t5_stop6_latency", n, 11);
    check("t5_stop6_q", q_m, 6);
    check("t5_stop6_dir", dir, 1);
    check("t5_stop6_pend", pend, 8'h04);
    wait_close(n);
    check("t5_stop6_door", n, 6);
    wait_door(n);
    check("t5_stop2_latency", n, 21);
    check("t5_stop2_q", q_m, 2);
    check("t5_stop2_dir", dir, 0);
    check("t5_stop2_pend", pend, 0);
    wait_close(n);

    // Reset while moving
    req = 8'h20; tick(1); req = 8'h00;
    tick(2);
    check("t6_moving_pre", moving, 1);
    check("t6_q_pre", q_m, 2);
    rst = 1'b0;
    #1;
    check("t6_rst_enb", enb, 0);
    check("t6_rst_modo", modo, 1);
    check("t6_rst_data", data, 0);
    check("t6_rst_dir", dir, 1);
    check("t6_rst_moving", moving, 0);
    check("t6_rst_door", door_open, 0);
    check("t6_rst_pend", pend, 0);
    tick(2);
    rst = 1'b1;
    tick(1);
    check("t6_init_enb", enb, 1);
    check("t6_init_modo", modo, 1);
    tick(1);
    check("t6_reload_q", q_m, 0);
    base = steps; flag = 1'b0;
    repeat (40) begin
      tick(1);
      if (moving || door_open) flag = 1'b1;
    end
    check("t6_no_stale", flag, 0);
    check("t6_no_steps", steps - base, 0);
    check("t6_pend_end", pend, 0);

    // Position fault keeps pending calls
    force_en = 1'b1; force_val = 4'd12; req = 8'h20;
    tick(1);
    force_en = 1'b0; req = 8'h00;
    check("t7_q_forced", q_m, 12);
    check("t7_pend_pre", pend, 8'h20);
    tick(1);
    check("t7_init_enb", enb, 1);
    check("t7_init_modo", modo, 1);
    check("t7_init_data", data, 0);
    check("t7_pend_kept", pend, 8'h20);
    check("t7_moving", moving, 0);
    tick(1);
    check("t7_reload_q", q_m, 0);
    wait_door(n);
    check("t7_latency", n, 26);
    check("t7_q", q_m, 5);
    check("no_illegal_steps", bad_steps, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
